// File: rtl/mips_pkg.sv
// Shared widths and the write-back entry type for the 64-bit MIPS datapath.
package mips_pkg;
  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_entry_fifo.sv
// In-order write-back entry store: up to two pushes (a then b) and one pop per clock.
// With WB_BYPASS_EN defined, the raw storage, head pointer and count are exported for searching.
module wb_entry_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_a_i,
  input  wb_entry_t     entry_a_i,
  input  logic          push_b_i,
  input  wb_entry_t     entry_b_i,
  input  logic          pop_i,
  output wb_entry_t     head_entry_o,
  output logic [CW-1:0] count_o
`ifdef WB_BYPASS_EN
  ,
  output wb_entry_t     entries_o [DEPTH],
  output logic [PW-1:0] head_ptr_o
`endif
);

  wb_entry_t     entries_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] tail_inc;

  assign tail_inc = tail_q + PW'(1);

  // push_b is only ever asserted together with push_a, so it lands one slot past a.
  always_ff @(posedge clk) begin
    if (push_a_i) entries_q[tail_q]   <= entry_a_i;
    if (push_b_i) entries_q[tail_inc] <= entry_b_i;
  end

  always_comb begin
    head_d  = head_q + (pop_i ? PW'(1) : PW'(0));
    tail_d  = tail_q + PW'(push_a_i) + PW'(push_b_i);
    count_d = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_entry_o = entries_q[head_q];
  assign count_o      = count_q;

`ifdef WB_BYPASS_EN
  assign entries_o  = entries_q;
  assign head_ptr_o = head_q;
`endif

endmodule

// File: rtl/regfile_write_queue.sv
// Write-side initiator for the register file: accepts load and ALU results, queues them in
// order and issues one registered write per clock. Optional WB_BYPASS_EN adds a read-bypass search.
module regfile_write_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [XLEN-1:0]   mem_data,
  output logic              mem_ready,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_dest,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              wb_stall,
  output logic [REG_AW-1:0] write_addr,
  output logic [XLEN-1:0]   write_reg_data,
  output logic              regWrite_en,
  output logic              queue_empty
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0] byp_addr,
  output logic              byp_hit,
  output logic [XLEN-1:0]   byp_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     count;
  logic [CW-1:0]     free_slots;
  wb_entry_t         head_entry;
  logic              mem_push, alu_push;
  logic              push_a, push_b, pop;
  wb_entry_t         entry_a, entry_b;
  logic              regWrite_en_q, regWrite_en_d;
  logic [REG_AW-1:0] write_addr_q, write_addr_d;
  logic [XLEN-1:0]   write_data_q, write_data_d;

  // Readiness looks only at the current occupancy; a pop this cycle frees nothing yet.
  assign free_slots = CW'(DEPTH) - count;
  assign mem_ready  = (free_slots != '0);
  assign alu_ready  = (free_slots >= CW'(2)) | ((free_slots != '0) & ~mem_valid);

  // $0 writes complete the handshake but never reach the queue.
  assign mem_push = mem_valid & mem_ready & (mem_dest != REG_ZERO);
  assign alu_push = alu_valid & alu_ready & (alu_dest != REG_ZERO);

  always_comb begin
    push_a  = mem_push | alu_push;
    push_b  = mem_push & alu_push;
    entry_a = mem_push ? wb_entry_t'{dest: mem_dest, data: mem_data}
                       : wb_entry_t'{dest: alu_dest, data: alu_data};
    entry_b = wb_entry_t'{dest: alu_dest, data: alu_data};
  end

  assign pop = (count != '0) & ~wb_stall;

`ifdef WB_BYPASS_EN
  wb_entry_t     fifo_entries [DEPTH];
  logic [PW-1:0] head_ptr;
`endif

  wb_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_a_i     (push_a),
    .entry_a_i    (entry_a),
    .push_b_i     (push_b),
    .entry_b_i    (entry_b),
    .pop_i        (pop),
    .head_entry_o (head_entry),
    .count_o      (count)
`ifdef WB_BYPASS_EN
    ,
    .entries_o    (fifo_entries),
    .head_ptr_o   (head_ptr)
`endif
  );

  always_comb begin
    regWrite_en_d = pop;
    write_addr_d  = write_addr_q;
    write_data_d  = write_data_q;
    if (pop) begin
      write_addr_d = head_entry.dest;
      write_data_d = head_entry.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite_en_q <= 1'b0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
    end else begin
      regWrite_en_q <= regWrite_en_d;
      write_addr_q  <= write_addr_d;
      write_data_q  <= write_data_d;
    end
  end

  assign regWrite_en    = regWrite_en_q;
  assign write_addr     = write_addr_q;
  assign write_reg_data = write_data_q;
  assign queue_empty    = (count == '0) & ~regWrite_en_q;

`ifdef WB_BYPASS_EN
  logic [PW-1:0] age_idx [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    assign age_idx[gi] = head_ptr + PW'(gi);
  end

  // Scan oldest to youngest so the youngest match overrides; the output register is oldest.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (regWrite_en_q && (write_addr_q == byp_addr)) begin
      byp_hit  = 1'b1;
      byp_data = write_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (fifo_entries[age_idx[i]].dest == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = fifo_entries[age_idx[i]].data;
      end
    end
    if (byp_addr == REG_ZERO) begin
      byp_hit  = 1'b0;
      byp_data = '0;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed table-driven bench for regfile_write_queue, plus hand sequences for reset and bypass.
module tb_regfile_write_queue;
  import mips_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_valid, alu_valid, wb_stall;
  logic [REG_AW-1:0] mem_dest, alu_dest;
  logic [XLEN-1:0]   mem_data, alu_data;
  logic              mem_ready, alu_ready;
  logic [REG_AW-1:0] write_addr;
  logic [XLEN-1:0]   write_reg_data;
  logic              regWrite_en, queue_empty;
`ifdef WB_BYPASS_EN
  logic [REG_AW-1:0] byp_addr;
  logic              byp_hit;
  logic [XLEN-1:0]   byp_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_dest       (mem_dest),
    .mem_data       (mem_data),
    .mem_ready      (mem_ready),
    .alu_valid      (alu_valid),
    .alu_dest       (alu_dest),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .wb_stall       (wb_stall),
    .write_addr     (write_addr),
    .write_reg_data (write_reg_data),
    .regWrite_en    (regWrite_en),
    .queue_empty    (queue_empty)
`ifdef WB_BYPASS_EN
    ,
    .byp_addr       (byp_addr),
    .byp_hit        (byp_hit),
    .byp_data       (byp_data)
`endif
  );

  typedef struct {
    logic        mv;
    logic [4:0]  md;
    logic [63:0] mdat;
    logic        av;
    logic [4:0]  ad;
    logic [63:0] adat;
    logic        st;
    logic        e_mr;
    logic        e_ar;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    logic        e_qe;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mv, input logic [4:0] md, input logic [63:0] mdat,
                              input logic av, input logic [4:0] ad, input logic [63:0] adat,
                              input logic st, input logic e_mr, input logic e_ar,
                              input logic e_en, input logic [4:0] e_addr,
                              input logic [63:0] e_data, input logic e_qe);
    vec_t v;
    v.mv = mv; v.md = md; v.mdat = mdat; v.av = av; v.ad = ad; v.adat = adat; v.st = st;
    v.e_mr = e_mr; v.e_ar = e_ar; v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data;
    v.e_qe = e_qe;
    return v;
  endfunction

  function automatic vec_t idle(input logic e_en, input logic [4:0] e_addr,
                                input logic [63:0] e_data, input logic e_qe);
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 1, e_en, e_addr, e_data, e_qe);
  endfunction

  task automatic drive(input logic mv, input logic [4:0] md, input logic [63:0] mdat,
                       input logic av, input logic [4:0] ad, input logic [63:0] adat,
                       input logic st);
    mem_valid = mv; mem_dest = md; mem_data = mdat;
    alu_valid = av; alu_dest = ad; alu_data = adat;
    wb_stall  = st;
  endtask

  localparam logic [63:0] X16 = 64'h0000_0000_8C9D_0004;
  localparam logic [63:0] DA  = 64'hAAAA_0000_0000_0003;
  localparam logic [63:0] DB  = 64'hBBBB_0000_0000_0005;
  localparam logic [63:0] D1  = 64'h1111, D2 = 64'h2222, D3 = 64'h3333, D4 = 64'h4444;
  localparam logic [63:0] D9  = 64'h9999, D10 = 64'hA0A0, D11 = 64'hB1B1;
  localparam logic [63:0] D20 = 64'h2020, D21 = 64'h2121;

  initial begin
    // single ALU write to r16
    vecs[0]  = mk(0, 0, 0, 1, 16, X16, 0,  1, 1, 0, 0, 0, 0);
    vecs[1]  = idle(1, 16, X16, 0);
    vecs[2]  = idle(0, 16, X16, 1);
    // mem r3 and alu r5 together: r3 first
    vecs[3]  = mk(1, 3, DA, 1, 5, DB, 0,   1, 1, 0, 16, X16, 0);
    vecs[4]  = idle(1, 3, DA, 0);
    vecs[5]  = idle(1, 5, DB, 0);
    vecs[6]  = idle(0, 5, DB, 1);
    // $0 destination is accepted but never written
    vecs[7]  = mk(0, 0, 0, 1, 0, '1, 0,    1, 1, 0, 5, DB, 1);
    vecs[8]  = idle(0, 5, DB, 1);
    // fill under stall, full ignores inputs, then drain in order
    vecs[9]  = mk(1, 1, D1, 1, 2, D2, 1,   1, 1, 0, 5, DB, 0);
    vecs[10] = mk(1, 3, D3, 1, 4, D4, 1,   1, 1, 0, 5, DB, 0);
    vecs[11] = mk(1, 9, D9, 1, 10, D10, 1, 0, 0, 0, 5, DB, 0);
    vecs[12] = mk(1, 9, D9, 1, 10, D10, 0, 0, 0, 1, 1, D1, 0);
    // one free slot with mem_valid: alu refused; mem to $0 dropped
    vecs[13] = mk(1, 0, D9, 1, 11, D11, 0, 1, 0, 1, 2, D2, 0);
    vecs[14] = idle(1, 3, D3, 0);
    vecs[15] = idle(1, 4, D4, 0);
    vecs[16] = idle(0, 4, D4, 1);
    // push and pop in the same cycle
    vecs[17] = mk(0, 0, 0, 1, 20, D20, 0,  1, 1, 0, 4, D4, 0);
    vecs[18] = mk(0, 0, 0, 1, 21, D21, 0,  1, 1, 1, 20, D20, 0);
    vecs[19] = idle(1, 21, D21, 0);
    vecs[20] = idle(0, 21, D21, 1);

    drive(0, 0, 0, 0, 0, 0, 0);
`ifdef WB_BYPASS_EN
    byp_addr = '0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_en",    {63'd0, regWrite_en}, 64'd0);
    check("reset_addr",  {59'd0, write_addr}, 64'd0);
    check("reset_data",  write_reg_data, 64'd0);
    check("reset_empty", {63'd0, queue_empty}, 64'd1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].mv, vecs[i].md, vecs[i].mdat, vecs[i].av, vecs[i].ad, vecs[i].adat,
            vecs[i].st);
      #1;
      check($sformatf("v%0d_mem_ready", i), {63'd0, mem_ready}, {63'd0, vecs[i].e_mr});
      check($sformatf("v%0d_alu_ready", i), {63'd0, alu_ready}, {63'd0, vecs[i].e_ar});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_en", i),    {63'd0, regWrite_en}, {63'd0, vecs[i].e_en});
      check($sformatf("v%0d_addr", i),  {59'd0, write_addr}, {59'd0, vecs[i].e_addr});
      check($sformatf("v%0d_data", i),  write_reg_data, vecs[i].e_data);
      check($sformatf("v%0d_empty", i), {63'd0, queue_empty}, {63'd0, vecs[i].e_qe});
      $display("vec %0d: en=%0b addr=%0d data=%0h empty=%0b", i, regWrite_en, write_addr,
               write_reg_data, queue_empty);
    end

    // asynchronous reset with three entries pending
    @(negedge clk);
    drive(1, 1, D1, 1, 2, D2, 1);
    @(negedge clk);
    drive(0, 0, 0, 1, 3, D3, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    check("rstq_pending", {63'd0, queue_empty}, 64'd0);
    #2 rst = 1'b1;
    #1;
    check("rstq_en",    {63'd0, regWrite_en}, 64'd0);
    check("rstq_empty", {63'd0, queue_empty}, 64'd1);
    check("rstq_addr",  {59'd0, write_addr}, 64'd0);
    check("rstq_data",  write_reg_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_stall = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rstq_nowrite%0d", c), {63'd0, regWrite_en}, 64'd0);
    end
    $display("reset mid-queue: en=%0b empty=%0b", regWrite_en, queue_empty);

`ifdef WB_BYPASS_EN
    // r7=1 then r7=2 pending: youngest wins, $0 never hits
    @(negedge clk);
    drive(0, 0, 0, 1, 7, 64'd1, 1);
    @(negedge clk);
    drive(0, 0, 0, 1, 7, 64'd2, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    byp_addr = 5'd7;
    #1;
    check("byp7_hit",  {63'd0, byp_hit}, 64'd1);
    check("byp7_data", byp_data, 64'd2);
    byp_addr = 5'd0;
    #1;
    check("byp0_hit",  {63'd0, byp_hit}, 64'd0);
    byp_addr = 5'd5;
    #1;
    check("byp5_hit",  {63'd0, byp_hit}, 64'd0);
    byp_addr = 5'd7;
    wb_stall = 1'b0;
    @(posedge clk);
    #1;
    check("byp_pop1_hit",  {63'd0, byp_hit}, 64'd1);
    check("byp_pop1_data", byp_data, 64'd2);
    @(posedge clk);
    #1;
    check("byp_out_hit",  {63'd0, byp_hit}, 64'd1);
    check("byp_out_data", byp_data, 64'd2);
    @(posedge clk);
    #1;
    check("byp_done_hit", {63'd0, byp_hit}, 64'd0);
    $display("bypass: hit=%0b data=%0h", byp_hit, byp_data);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
